// File: rtl/alu_operand_stage_pkg.sv
// Opcode and ALU-function definitions shared by the operand stage, its
// instruction interface, the register file and the testbench.
//   alu_functions_t : function select driven into the ALU (ALU_NOP added)
//   op_t            : decoded instruction opcode
//   op_to_alu()     : opcode -> ALU function, unsupported opcodes map to ALU_NOP
//   is_imm()        : true when operand b comes from the sign-extended immediate
package opcodes;

   typedef enum logic [1:0] {
      ALU_ADD  = 2'd0,
      ALU_MULT = 2'd1,
      ALU_NOP  = 2'd3
   } alu_functions_t;

   typedef enum logic [2:0] {
      OP_NOP  = 3'd0,
      OP_ADD  = 3'd1,
      OP_ADDI = 3'd2,
      OP_MUL  = 3'd3,
      OP_MULI = 3'd4
   } op_t;

   // Anything that is not an add or multiply retires as "illegal" downstream,
   // so it must select ALU_NOP here.
   function automatic alu_functions_t op_to_alu(input op_t op);
      case (op)
         OP_ADD, OP_ADDI: return ALU_ADD;
         OP_MUL, OP_MULI: return ALU_MULT;
         default:         return ALU_NOP;
      endcase
   endfunction

   function automatic logic is_imm(input op_t op);
      return (op == OP_ADDI) || (op == OP_MULI);
   endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// Instruction handshake between the decoder (master) and the operand stage
// (slave).
//   in_valid : instruction present            (master -> slave)
//   in_ready : stage can accept an instruction (slave -> master)
//   Op       : decoded opcode
//   Rd/Rs/Rt : destination and source register indices
//   Imm      : n-bit two's complement immediate
interface alu_operand_stage_if
   import opcodes::*;
#(
   parameter int n    = 8,
   parameter int REGS = 8
) ();

   localparam int RW = $clog2(REGS);

   logic          in_valid;
   logic          in_ready;
   op_t           Op;
   logic [RW-1:0] Rd;
   logic [RW-1:0] Rs;
   logic [RW-1:0] Rt;
   logic [n-1:0]  Imm;

   modport master (output in_valid, Op, Rd, Rs, Rt, Imm, input in_ready);
   modport slave  (input in_valid, Op, Rd, Rs, Rt, Imm, output in_ready);

endinterface

// File: rtl/alu_operand_stage_regfile.sv
// Small register file for the operand stage.
//   Clock, Reset        : rising-edge clock, synchronous active-high clear
//   rd_addr_a/rd_data_a : combinational read port A
//   rd_addr_b/rd_data_b : combinational read port B
//   wr_en/wr_addr/wr_data : synchronous write port
// Register 0 is hard-wired to zero: it reads as 0 and ignores writes.
module alu_operand_stage_regfile #(
   parameter int n    = 8,
   parameter int REGS = 8
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic [$clog2(REGS)-1:0]  rd_addr_a,
   output logic [n:0]               rd_data_a,
   input  logic [$clog2(REGS)-1:0]  rd_addr_b,
   output logic [n:0]               rd_data_b,
   input  logic                     wr_en,
   input  logic [$clog2(REGS)-1:0]  wr_addr,
   input  logic [n:0]               wr_data
);

   logic [n:0] regs [REGS];

   // Storage: everything clears on reset; writes aimed at R0 are dropped so
   // the slot stays at zero even though the read mux already masks it.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         for (int i = 0; i < REGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_en && (wr_addr != '0)) begin
         regs[wr_addr] <= wr_data;
      end
   end

   assign rd_data_a = (rd_addr_a == '0) ? '0 : regs[rd_addr_a];
   assign rd_data_b = (rd_addr_b == '0) ? '0 : regs[rd_addr_b];

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch / writeback stage sitting directly in front of the ALU.
//   Clock, Reset : rising-edge clock, synchronous active-high reset
//   instr        : instruction handshake (slave side)
//   a, b         : ALU operands, valid during the ISSUE cycle, 0 otherwise
//   Function     : ALU function select, ALU_NOP outside ISSUE
//   q            : combinational ALU result, captured at the end of ISSUE
//   done         : one-cycle pulse after a register writeback
//   result       : last value written back (held)
//   illegal      : one-cycle pulse after an unsupported opcode retires
// One instruction every two cycles: IDLE accepts, ISSUE drives the ALU and
// writes back, so an instruction can always read its predecessor's result.
module alu_operand_stage
   import opcodes::*;
#(
   parameter int n    = 8,
   parameter int REGS = 8
) (
   input  logic            Clock,
   input  logic            Reset,
   alu_operand_stage_if.slave instr,
   output logic [n:0]      a,
   output logic [n:0]      b,
   output alu_functions_t  Function,
   input  logic [n:0]      q,
   output logic            done,
   output logic [n:0]      result,
   output logic            illegal
);

   localparam int RW = $clog2(REGS);

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t        state;
   logic          in_ready_q;
   logic [RW-1:0] rd_q;
   logic [n:0]    rdata_s;
   logic [n:0]    rdata_t;
   logic [n:0]    imm_ext;
   logic          wr_en;

   assign instr.in_ready = in_ready_q;
   assign imm_ext        = {instr.Imm[n-1], instr.Imm};

   // Writeback happens on the edge that ends ISSUE; an ALU_NOP instruction
   // never touches the register file.
   assign wr_en = (state == ISSUE) && (Function != ALU_NOP);

   // Source registers are read straight from the incoming indices at the
   // accepting edge; nothing is written on that edge, so the values match
   // what the latched indices would read during ISSUE.
   alu_operand_stage_regfile #(
      .n    (n),
      .REGS (REGS)
   ) u_regfile (
      .Clock     (Clock),
      .Reset     (Reset),
      .rd_addr_a (instr.Rs),
      .rd_data_a (rdata_s),
      .rd_addr_b (instr.Rt),
      .rd_data_b (rdata_t),
      .wr_en     (wr_en),
      .wr_addr   (rd_q),
      .wr_data   (q)
   );

   // Control FSM with every output registered. Accepting an instruction
   // loads the ALU operands for the ISSUE cycle; leaving ISSUE clears them,
   // raises done or illegal for one cycle and re-opens the handshake.
   // Reset wins over an in-flight writeback.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state      <= IDLE;
         in_ready_q <= 1'b1;
         rd_q       <= '0;
         a          <= '0;
         b          <= '0;
         Function   <= ALU_NOP;
         done       <= 1'b0;
         illegal    <= 1'b0;
         result     <= '0;
      end else begin
         done    <= 1'b0;
         illegal <= 1'b0;
         case (state)
            IDLE: begin
               if (instr.in_valid && in_ready_q) begin
                  state      <= ISSUE;
                  in_ready_q <= 1'b0;
                  rd_q       <= instr.Rd;
                  a          <= rdata_s;
                  b          <= is_imm(instr.Op) ? imm_ext : rdata_t;
                  Function   <= op_to_alu(instr.Op);
               end
            end
            ISSUE: begin
               state      <= IDLE;
               in_ready_q <= 1'b1;
               a          <= '0;
               b          <= '0;
               Function   <= ALU_NOP;
               if (Function == ALU_NOP) begin
                  illegal <= 1'b1;
               end else begin
                  done   <= 1'b1;
                  result <= q;
               end
            end
            default: begin
               state      <= IDLE;
               in_ready_q <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Self-checking bench for alu_operand_stage. A behavioural ALU closes the
// q loop; a reference register file predicts each retirement and pushes it
// to a scoreboard that the negedge monitor pops on done/illegal.
module tb_alu_operand_stage;
   import opcodes::*;

   localparam int n    = 8;
   localparam int REGS = 8;
   localparam int RW   = $clog2(REGS);

   logic           Clock = 1'b0;
   logic           Reset;
   logic [n:0]     a;
   logic [n:0]     b;
   logic [n:0]     q;
   logic [n:0]     result;
   alu_functions_t Function;
   logic           done;
   logic           illegal;

   alu_operand_stage_if #(.n(n), .REGS(REGS)) instr ();

   alu_operand_stage #(.n(n), .REGS(REGS)) dut (
      .Clock    (Clock),
      .Reset    (Reset),
      .instr    (instr),
      .a        (a),
      .b        (b),
      .Function (Function),
      .q        (q),
      .done     (done),
      .result   (result),
      .illegal  (illegal)
   );

   always #5 Clock = ~Clock;

   // Behavioural ALU: results truncated to n+1 bits
   logic [2*n+1:0] product;
   always_comb begin
      product = (2*n+2)'(a) * (2*n+2)'(b);
      case (Function)
         ALU_ADD:  q = a + b;
         ALU_MULT: q = product[n:0];
         default:  q = '0;
      endcase
   end

   typedef struct {
      logic [n:0]     a;
      logic [n:0]     b;
      alu_functions_t f;
      logic           chkAB;
      logic           isDone;
      logic [n:0]     res;
   } exp_t;

   exp_t       sbQueue[$];
   logic [n:0] mregs [REGS];
   logic [n:0] mresult;
   int         checkCount = 0;
   int         errorCount = 0;
   int         cycle = 0;
   int         acceptCycle = 0;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Monitor: capture operands while ISSUE is visible, then score the
   // retirement that follows it.
   logic           seenIssue = 1'b0;
   logic [n:0]     obsA;
   logic [n:0]     obsB;
   alu_functions_t obsF;
   always @(negedge Clock) begin
      exp_t e;
      cycle++;
      if (Reset) begin
         seenIssue = 1'b0;
      end else begin
         if (!instr.in_ready) begin
            seenIssue = 1'b1;
            obsA = a;
            obsB = b;
            obsF = Function;
         end
         if (done || illegal) begin
            if (sbQueue.size() == 0) begin
               checkOutput("unexpected_retire", 32'({done, illegal}), 32'd0);
            end else begin
               e = sbQueue.pop_front();
               checkOutput("issue_seen", 32'(seenIssue), 32'd1);
               checkOutput("function", 32'(obsF), 32'(e.f));
               if (e.chkAB) begin
                  checkOutput("operand_a", 32'(obsA), 32'(e.a));
                  checkOutput("operand_b", 32'(obsB), 32'(e.b));
               end
               checkOutput("done", 32'(done), 32'(e.isDone));
               checkOutput("illegal", 32'(illegal), 32'(!e.isDone));
               checkOutput("result", 32'(result), 32'(e.res));
               seenIssue = 1'b0;
            end
         end
      end
   end

   // Present one instruction and leave in_valid high after acceptance.
   task automatic applyStimulus(input op_t op, input logic [RW-1:0] rd, input logic [RW-1:0] rs,
                                input logic [RW-1:0] rt, input logic [n-1:0] imm, input bit track);
      exp_t           e;
      bit             accepted;
      logic [2*n+1:0] prod;
      logic [n:0]     eq;
      accepted = 1'b0;
      @(negedge Clock);
      instr.in_valid = 1'b1;
      instr.Op       = op;
      instr.Rd       = rd;
      instr.Rs       = rs;
      instr.Rt       = rt;
      instr.Imm      = imm;
      for (int i = 0; i < 20; i++) begin
         if (instr.in_ready) begin
            @(posedge Clock);
            accepted = 1'b1;
            break;
         end
         @(negedge Clock);
      end
      if (!accepted) begin
         checkOutput("accept_timeout", 32'd0, 32'd1);
         return;
      end
      acceptCycle = cycle;
      if (track) begin
         e.a = mregs[rs];
         if (op == OP_ADD || op == OP_ADDI) e.f = ALU_ADD;
         else if (op == OP_MUL || op == OP_MULI) e.f = ALU_MULT;
         else e.f = ALU_NOP;
         e.b      = (op == OP_ADDI || op == OP_MULI) ? {imm[n-1], imm} : mregs[rt];
         e.chkAB  = (e.f != ALU_NOP);
         e.isDone = (e.f != ALU_NOP);
         prod     = (2*n+2)'(e.a) * (2*n+2)'(e.b);
         eq       = (e.f == ALU_ADD) ? e.a + e.b : prod[n:0];
         if (e.isDone) begin
            if (rd != '0) mregs[rd] = eq;
            mresult = eq;
         end
         e.res = mresult;
         sbQueue.push_back(e);
      end
   endtask

   task automatic idleBus();
      @(negedge Clock);
      instr.in_valid = 1'b0;
   endtask

   task automatic drainQueue();
      for (int i = 0; i < 50; i++) begin
         if (sbQueue.size() == 0) break;
         @(negedge Clock);
      end
      checkOutput("queue_drained", 32'(sbQueue.size()), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   int a1, a2, a3;

   // Main sequence
   initial begin
      instr.in_valid = 1'b0;
      instr.Op       = OP_NOP;
      instr.Rd       = '0;
      instr.Rs       = '0;
      instr.Rt       = '0;
      instr.Imm      = '0;
      Reset          = 1'b1;
      for (int i = 0; i < REGS; i++) mregs[i] = '0;
      mresult = '0;
      repeat (3) @(negedge Clock);
      Reset = 1'b0;
      @(negedge Clock);
      checkOutput("rst_in_ready", 32'(instr.in_ready), 32'd1);
      checkOutput("rst_a", 32'(a), 32'd0);
      checkOutput("rst_b", 32'(b), 32'd0);
      checkOutput("rst_function", 32'(Function), 32'(ALU_NOP));
      checkOutput("rst_done", 32'(done), 32'd0);
      checkOutput("rst_illegal", 32'(illegal), 32'd0);
      checkOutput("rst_result", 32'(result), 32'd0);

      // Every register reads zero after reset
      for (int i = 0; i < REGS; i++) begin
         applyStimulus(OP_ADD, 3'd0, RW'(i), RW'(i), 8'd0, 1'b1);
      end
      idleBus();

      applyStimulus(OP_ADDI, 3'd1, 3'd0, 3'd0, 8'd5, 1'b1);
      idleBus();
      applyStimulus(OP_MUL, 3'd2, 3'd1, 3'd1, 8'd0, 1'b1);
      idleBus();
      applyStimulus(OP_ADDI, 3'd3, 3'd0, 3'd0, 8'hFF, 1'b1);
      idleBus();
      applyStimulus(OP_ADDI, 3'd0, 3'd0, 3'd0, 8'd7, 1'b1);
      applyStimulus(OP_ADD, 3'd4, 3'd0, 3'd0, 8'd0, 1'b1);
      idleBus();
      applyStimulus(OP_NOP, 3'd1, 3'd2, 3'd3, 8'd0, 1'b1);
      applyStimulus(OP_ADD, 3'd7, 3'd1, 3'd0, 8'd0, 1'b1);
      applyStimulus(OP_MULI, 3'd5, 3'd3, 3'd0, 8'd2, 1'b1);
      applyStimulus(OP_MUL, 3'd6, 3'd2, 3'd2, 8'd0, 1'b1);
      idleBus();
      drainQueue();

      // Held in_valid: one acceptance every second cycle, RAW without stalls
      applyStimulus(OP_ADDI, 3'd1, 3'd1, 3'd0, 8'd1, 1'b1);
      a1 = acceptCycle;
      applyStimulus(OP_ADD, 3'd2, 3'd1, 3'd1, 8'd0, 1'b1);
      a2 = acceptCycle;
      applyStimulus(OP_MULI, 3'd3, 3'd2, 3'd0, 8'hFE, 1'b1);
      a3 = acceptCycle;
      idleBus();
      checkOutput("accept_spacing_1", 32'(a2 - a1), 32'd2);
      checkOutput("accept_spacing_2", 32'(a3 - a2), 32'd2);
      drainQueue();

      // Reset during ISSUE discards the writeback
      applyStimulus(OP_ADDI, 3'd5, 3'd0, 3'd0, 8'd9, 1'b0);
      #1;
      Reset          = 1'b1;
      instr.in_valid = 1'b0;
      repeat (2) @(negedge Clock);
      Reset = 1'b0;
      for (int i = 0; i < REGS; i++) mregs[i] = '0;
      mresult = '0;
      @(negedge Clock);
      checkOutput("post_rst_in_ready", 32'(instr.in_ready), 32'd1);
      checkOutput("post_rst_done", 32'(done), 32'd0);
      checkOutput("post_rst_result", 32'(result), 32'd0);
      applyStimulus(OP_ADD, 3'd6, 3'd5, 3'd0, 8'd0, 1'b1);
      idleBus();
      drainQueue();

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
